// File: rtl/arki_pkg.sv
// Shared types and constants for the LEGv8 pipeline front end.
package arki_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_DROP = 2'd1,
        F_BUF  = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/if_skid.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode is stalled.
module if_skid
    import arki_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [63:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [63:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        // A clear (redirect) wins over a same-cycle load.
        if (clear_i || drain_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake, skid buffer and IF/ID register.
module if_stage
    import arki_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [63:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  drop_addr_q, drop_addr_d;
    logic         id_valid_q, id_valid_d;
    logic [63:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_instr_q, id_instr_d;

    logic         skid_load, skid_drain, skid_clear;
    logic         skid_valid;
    logic [63:0]  skid_pc;
    logic [31:0]  skid_instr;
    logic [63:0]  pc_inc;

    assign pc_inc = pc_q + 64'(INSTR_BYTES);

    if_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        skid_load   = 1'b0;
        skid_drain  = 1'b0;
        skid_clear  = 1'b0;

        if (redirect_i) begin
            id_valid_d = 1'b0;
            pc_d       = {redirect_pc_i[63:2], 2'b00};
            skid_clear = 1'b1;
            unique case (state_q)
                F_REQ: begin
                    // Unacked request keeps running on the bus; remember its address.
                    if (imem_ack_i) begin
                        state_d = F_REQ;
                    end else begin
                        state_d     = F_DROP;
                        drop_addr_d = pc_q;
                    end
                end
                F_DROP:  state_d = imem_ack_i ? F_REQ : F_DROP;
                F_BUF:   state_d = F_REQ;
                default: state_d = F_REQ;
            endcase
        end else begin
            unique case (state_q)
                F_REQ: begin
                    if (imem_ack_i) begin
                        pc_d = pc_inc;
                        if (stall_i) begin
                            skid_load = 1'b1;
                            state_d   = F_BUF;
                        end else begin
                            id_valid_d = 1'b1;
                            id_pc_d    = pc_q;
                            id_instr_d = imem_rdata_i;
                        end
                    end else if (!stall_i) begin
                        id_valid_d = 1'b0;
                    end
                end
                F_DROP: begin
                    if (imem_ack_i) state_d = F_REQ;
                    if (!stall_i) id_valid_d = 1'b0;
                end
                F_BUF: begin
                    if (!stall_i) begin
                        id_valid_d = skid_valid;
                        id_pc_d    = skid_pc;
                        id_instr_d = skid_instr;
                        skid_drain = 1'b1;
                        state_d    = F_REQ;
                    end
                end
                default: state_d = F_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= F_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_instr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
        end
    end

    assign imem_req_o    = (state_q == F_REQ) || (state_q == F_DROP);
    assign imem_addr_o   = (state_q == F_DROP) ? drop_addr_q : pc_q;
    assign if_id_valid_o = id_valid_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_instr_o = id_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table plus hand sequences for buffer, drop, wrap and reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, redirect_i, imem_ack_i;
    logic [63:0] redirect_pc_i;
    logic [31:0] imem_rdata_i;
    logic        imem_req_o, if_id_valid_o;
    logic [63:0] imem_addr_o, if_id_pc_o;
    logic [31:0] if_id_instr_o;

    int total = 0;
    int bad   = 0;

    if_stage #(.RESET_PC(64'h100)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_vld;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] w(input logic [63:0] a);
        return 32'hF840_0000 + a[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [63:0] rpc,
                         input logic ak, input logic [31:0] dat);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ack_i    = ak;
        imem_rdata_i  = dat;
    endtask

    // Apply inputs for one cycle and step to the next falling edge.
    task automatic step(input logic st, input logic rd, input logic [63:0] rpc,
                        input logic ak, input logic [31:0] dat);
        drive(st, rd, rpc, ak, dat);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Expected values describe outputs in the cycle where the inputs are applied.
        vecs[0]  = '{1'b0, 1'b0, 64'h0,   1'b1, w(64'h100), 1'b1, 64'h100, 1'b0, 64'h0,   32'h0};
        vecs[1]  = '{1'b0, 1'b0, 64'h0,   1'b1, w(64'h104), 1'b1, 64'h104, 1'b1, 64'h100, w(64'h100)};
        vecs[2]  = '{1'b1, 1'b0, 64'h0,   1'b1, w(64'h108), 1'b1, 64'h108, 1'b1, 64'h104, w(64'h104)};
        vecs[3]  = '{1'b1, 1'b0, 64'h0,   1'b0, 32'h0,      1'b0, 64'h10C, 1'b1, 64'h104, w(64'h104)};
        vecs[4]  = '{1'b1, 1'b0, 64'h0,   1'b0, 32'h0,      1'b0, 64'h10C, 1'b1, 64'h104, w(64'h104)};
        vecs[5]  = '{1'b0, 1'b0, 64'h0,   1'b0, 32'h0,      1'b0, 64'h10C, 1'b1, 64'h104, w(64'h104)};
        vecs[6]  = '{1'b0, 1'b1, 64'h203, 1'b1, w(64'h10C), 1'b1, 64'h10C, 1'b1, 64'h108, w(64'h108)};
        vecs[7]  = '{1'b0, 1'b0, 64'h0,   1'b1, w(64'h200), 1'b1, 64'h200, 1'b0, 64'h0,   32'h0};
        vecs[8]  = '{1'b1, 1'b1, 64'h400, 1'b0, 32'h0,      1'b1, 64'h204, 1'b1, 64'h200, w(64'h200)};
        vecs[9]  = '{1'b0, 1'b0, 64'h0,   1'b0, 32'h0,      1'b1, 64'h204, 1'b0, 64'h0,   32'h0};
        vecs[10] = '{1'b0, 1'b0, 64'h0,   1'b1, w(64'h204), 1'b1, 64'h204, 1'b0, 64'h0,   32'h0};
        vecs[11] = '{1'b0, 1'b0, 64'h0,   1'b0, 32'h0,      1'b1, 64'h400, 1'b0, 64'h0,   32'h0};
        vecs[12] = '{1'b0, 1'b0, 64'h0,   1'b1, w(64'h400), 1'b1, 64'h400, 1'b0, 64'h0,   32'h0};
        vecs[13] = '{1'b0, 1'b0, 64'h0,   1'b0, 32'h0,      1'b1, 64'h404, 1'b1, 64'h400, w(64'h400)};
        vecs[14] = '{1'b0, 1'b0, 64'h0,   1'b0, 32'h0,      1'b1, 64'h404, 1'b0, 64'h0,   32'h0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst.req",   64'(imem_req_o),    64'h1);
        chk("rst.addr",  imem_addr_o,        64'h100);
        chk("rst.vld",   64'(if_id_valid_o), 64'h0);
        chk("rst.pc",    if_id_pc_o,         64'h0);
        chk("rst.instr", 64'(if_id_instr_o), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d.req", i),  64'(imem_req_o),    64'(vecs[i].e_req));
            chk($sformatf("v%0d.addr", i), imem_addr_o,        vecs[i].e_addr);
            chk($sformatf("v%0d.vld", i),  64'(if_id_valid_o), 64'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                chk($sformatf("v%0d.pc", i),    if_id_pc_o,         vecs[i].e_pc);
                chk($sformatf("v%0d.instr", i), 64'(if_id_instr_o), 64'(vecs[i].e_instr));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Buffered word discarded by a redirect: pc 0x404 parked, then redirect to 0x800.
        step(1'b1, 1'b0, 64'h0, 1'b1, w(64'h404));
        chk("buf.req", 64'(imem_req_o), 64'h0);
        step(1'b1, 1'b1, 64'h800, 1'b0, 32'h0);
        chk("bufredir.req",  64'(imem_req_o),    64'h1);
        chk("bufredir.addr", imem_addr_o,        64'h800);
        chk("bufredir.vld",  64'(if_id_valid_o), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1, w(64'h800));
        chk("bufredir.ifpc",  if_id_pc_o,         64'h800);
        chk("bufredir.instr", 64'(if_id_instr_o), 64'(w(64'h800)));

        // Two redirects while the stale request is pending: the latest target wins.
        step(1'b0, 1'b1, 64'h900, 1'b0, 32'h0);
        chk("drop1.addr", imem_addr_o, 64'h804);
        step(1'b0, 1'b1, 64'hA00, 1'b0, 32'h0);
        chk("drop2.addr", imem_addr_o, 64'h804);
        step(1'b0, 1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF);
        chk("drop3.addr", imem_addr_o,        64'hA00);
        chk("drop3.vld",  64'(if_id_valid_o), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1, w(64'hA00));
        chk("drop4.vld", 64'(if_id_valid_o), 64'h1);
        chk("drop4.pc",  if_id_pc_o,         64'hA00);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, w(64'hA04));
        chk("wrap.addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 1'b0, 64'h0, 1'b1, 32'h1234_5678);
        chk("wrap.next", imem_addr_o,         64'h0);
        chk("wrap.ifpc", if_id_pc_o,          64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap.ins",  64'(if_id_instr_o),  64'h1234_5678);
        chk("wrap.vld",  64'(if_id_valid_o),  64'h1);

        // Asynchronous reset while a request waits, between clock edges.
        drive(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.req",   64'(imem_req_o),    64'h1);
        chk("arst.addr",  imem_addr_o,        64'h100);
        chk("arst.vld",   64'(if_id_valid_o), 64'h0);
        chk("arst.pc",    if_id_pc_o,         64'h0);
        chk("arst.instr", 64'(if_id_instr_o), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 64'h0, 1'b1, w(64'h100));
        chk("post.pc",  if_id_pc_o,  64'h100);
        chk("post.addr", imem_addr_o, 64'h104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with IF/ID pipeline register for the LEGv8 pipeline. It owns the PC and issues requests to instruction memory over a req/ack handshake. A one-entry skid buffer absorbs responses that arrive while decode is stalled. It presents {valid, pc, instr} to the decode stage (register file, control, sign extension); taken branches resolved downstream redirect it.

## Interface
Parameters:
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard unit: hold IF/ID contents this cycle.
- redirect_i  in  1  taken branch/CBZ/CBNZ: squash the fetch path and load redirect_pc_i.
- redirect_pc_i  in  64  branch target; bits [1:0] are ignored and treated as 0.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  64  fetch address (= pc); stable while imem_req_o is high and unacked.
- imem_ack_i  in  1  response valid; may arrive in the same cycle as the request or any later cycle.
- imem_rdata_i  in  32  instruction word; valid when imem_ack_i is high.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_pc_o  out  64  PC of that instruction.
- if_id_instr_o  out  32  instruction word to decode.

## Operation
- State machine (three states):
  - F_REQ: request outstanding for pc.
  - F_DROP: stale request outstanding; its response is discarded.
  - F_BUF: fetched word parked in the skid buffer, with no request outstanding.
- imem_req_o = (state == F_REQ) || (state == F_DROP). imem_addr_o = pc in F_REQ and the stale address in F_DROP.
- Priority order: reset > redirect_i > stall_i > normal flow.
- F_REQ, ack, no redirect:
  - If stall_i = 0: load {1, pc, rdata} into IF/ID, pc <= pc+4, stay in F_REQ.
  - If stall_i = 1: write {pc, rdata} to the skid buffer, pc <= pc+4, go to F_BUF.
- F_REQ, no ack, no redirect: no change to the fetch path. If stall_i = 0, if_id_valid <= 0 (bubble).
- F_BUF, stall_i = 0: move the buffer into IF/ID (valid = 1), go to F_REQ. If stall_i = 1, hold everything.
- F_DROP: when ack arrives, discard rdata and go to F_REQ. If stall_i = 0, if_id_valid <= 0.
- redirect_i = 1:
  - if_id_valid <= 0 regardless of stall_i.
  - pc <= {redirect_pc_i[63:2], 2'b00}.
  - Skid buffer is discarded.
  - Next state:
    - F_REQ with ack this cycle, or F_BUF: go to F_REQ.
    - F_REQ without ack: go to F_DROP.
    - F_DROP without ack: stay in F_DROP; the latest target wins.
    - F_DROP with ack: go to F_REQ.
- pc arithmetic is modulo 2^64; pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- When stall_i holds IF/ID with valid = 1, if_id_pc_o and if_id_instr_o do not change.

## Timing
- Reset values:
  - state = F_REQ, pc = RESET_PC.
  - if_id_valid_o = 0, if_id_pc_o = 0, if_id_instr_o = 0.
  - Skid buffer is empty.
  - imem_req_o = 1 and imem_addr_o = RESET_PC while reset is high and immediately after it deasserts.
- Reset asserted mid-transaction: all state clears asynchronously. A late ack for the aborted request is not dropped; it is accepted as the response to the F_REQ request at RESET_PC. This is acceptable only because imem is reset by the same signal.
- Latency: an ack in cycle n makes the instruction visible on IF/ID in cycle n+1.
- Throughput with a zero-wait memory (ack in the request cycle): 1 instruction per cycle.
- Redirect asserted in cycle n: the IF/ID bubble is visible in cycle n+1. With a zero-wait memory, the first target instruction is on IF/ID in cycle n+2.
- Outputs are registered. The only combinational outputs are imem_req_o and imem_addr_o, which are functions of state and pc.

## Structure
- Shared package arki_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {F_REQ, F_DROP, F_BUF}.
  - localparam INSTR_BYTES = 4.
- Sub-module if_skid: one-entry buffer {valid, pc[63:0], instr[31:0]} with ports load, drain, clear. The FSM, PC register and IF/ID register stay in if_stage.

## Test plan
- Reset with RESET_PC = 64'h100 and zero-wait memory returning 32'hF840_0000 + addr -> imem_addr_o sequence 0x100, 0x104, 0x108 on consecutive cycles; IF/ID shows pc 0x100 one cycle after reset release, with valid = 1 on every subsequent cycle.
- Stall for 3 cycles while an ack arrives at pc 0x108 -> IF/ID holds pc 0x104; state goes to F_BUF and imem_req_o = 0. The cycle after stall drops, IF/ID = 0x108. No instruction is lost or duplicated.
- Memory with 2-cycle ack latency; redirect to 0x400 in the first wait cycle -> state goes to F_DROP and the stale ack data is never seen on IF/ID. The next request is at 0x400, and IF/ID shows pc 0x400 with valid = 1.
- Redirect to 0x203 while stall_i = 1 and IF/ID is valid -> if_id_valid_o = 0 next cycle; the next fetch address is 0x200.
- Redirect in the same cycle as an ack at 0x10C -> the 0x10C word is dropped and the next address is the target.
- PC at 64'hFFFF_FFFF_FFFF_FFFC with an ack -> next imem_addr_o = 0. Reset asserted mid-wait -> all outputs return to their reset values asynchronously, before the next clock edge.
